// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Load-use, memory-wait and halt stall controller for a
//               five-stage pipeline. Optional single-step gating is enabled
//               by defining PIPELINE_STEP_MODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        idExMemRead,
    input  logic [4:0]  idExRt,
    input  logic [4:0]  ifIdRs,
    input  logic [4:0]  ifIdRt,
    input  logic        memReq,
    input  logic        memAck,
    input  logic        haltInstr,
`ifdef PIPELINE_STEP_MODE_EN
    input  logic        stepMode,
    input  logic        stepPulse,
`endif
    output logic        pcEnable,
    output logic        ifIdEnable,
    output logic        idExEnable,
    output logic        exMemEnable,
    output logic        memWbEnable,
    output logic        idExFlush,
    output logic        halted,
    output logic        memTimeout,
    output logic [15:0] stallCount
);

    localparam logic [1:0]  c_RUN       = 2'd0;
    localparam logic [1:0]  c_MEM_WAIT  = 2'd1;
    localparam logic [1:0]  c_HALT      = 2'd2;
    localparam logic [7:0]  c_WAIT_MAX  = 8'hFF;
    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [7:0]  r_waitCnt;
    logic        r_memTimeout;
    logic        r_halted;
    logic [15:0] r_stallCount;

    logic [1:0]  w_nextState;
    logic        w_frontEn;
    logic        w_backEn;
    logic        w_flush;
    logic        w_countStall;
    logic        w_enterWait;
    logic        w_waitInc;
    logic        w_timeout;
    logic        w_hazard;
    logic        w_stepIdle;

    assign w_hazard = idExMemRead && (idExRt != 5'd0) &&
                      ((idExRt == ifIdRs) || (idExRt == ifIdRt));

`ifdef PIPELINE_STEP_MODE_EN
    // Without a step pulse the RUN state simply freezes; these cycles are not stalls.
    assign w_stepIdle = stepMode && !stepPulse;
`else
    assign w_stepIdle = 1'b0;
`endif

    always_comb begin
        w_nextState  = r_state;
        w_frontEn    = 1'b0;
        w_backEn     = 1'b0;
        w_flush      = 1'b0;
        w_countStall = 1'b0;
        w_enterWait  = 1'b0;
        w_waitInc    = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            c_RUN: begin
                if (w_stepIdle) begin
                    w_nextState = c_RUN;
                end else if (haltInstr) begin
                    w_countStall = 1'b1;
                    w_nextState  = c_HALT;
                end else if (memReq && !memAck) begin
                    w_countStall = 1'b1;
                    w_enterWait  = 1'b1;
                    w_nextState  = c_MEM_WAIT;
                end else if (w_hazard) begin
                    w_backEn     = 1'b1;
                    w_flush      = 1'b1;
                    w_countStall = 1'b1;
                end else begin
                    w_frontEn = 1'b1;
                    w_backEn  = 1'b1;
                end
            end
            c_MEM_WAIT: begin
                if (memAck) begin
                    w_frontEn   = 1'b1;
                    w_backEn    = 1'b1;
                    w_nextState = c_RUN;
                end else begin
                    w_countStall = 1'b1;
                    if (r_waitCnt == c_WAIT_MAX) begin
                        w_timeout   = 1'b1;
                        w_nextState = c_HALT;
                    end else begin
                        w_waitInc = 1'b1;
                    end
                end
            end
            c_HALT: begin
                w_nextState = c_HALT;
            end
            default: begin
                w_nextState = c_RUN;
            end
        endcase

        // Reset forces a full freeze regardless of state or inputs.
        if (reset) begin
            w_frontEn = 1'b0;
            w_backEn  = 1'b0;
            w_flush   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_RUN;
            r_waitCnt    <= 8'd0;
            r_memTimeout <= 1'b0;
            r_halted     <= 1'b0;
            r_stallCount <= 16'd0;
        end else begin
            r_state <= w_nextState;
            if (w_enterWait) begin
                r_waitCnt <= 8'd0;
            end else if (w_waitInc) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
            if (w_timeout) begin
                r_memTimeout <= 1'b1;
            end
            r_halted <= (w_nextState == c_HALT);
            if (w_countStall && (r_stallCount != c_STALL_MAX)) begin
                r_stallCount <= r_stallCount + 16'd1;
            end
        end
    end

    assign pcEnable    = w_frontEn;
    assign ifIdEnable  = w_frontEn;
    assign idExEnable  = w_backEn;
    assign exMemEnable = w_backEn;
    assign memWbEnable = w_backEn;
    assign idExFlush   = w_flush;
    assign halted      = r_halted;
    assign memTimeout  = r_memTimeout;
    assign stallCount  = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed and randomized self-checking bench for
//               pipeline_stall_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        idExMemRead;
    logic [4:0]  idExRt;
    logic [4:0]  ifIdRs;
    logic [4:0]  ifIdRt;
    logic        memReq;
    logic        memAck;
    logic        haltInstr;
    logic        stepMode  = 1'b0;
    logic        stepPulse = 1'b0;
    logic        pcEnable;
    logic        ifIdEnable;
    logic        idExEnable;
    logic        exMemEnable;
    logic        memWbEnable;
    logic        idExFlush;
    logic        halted;
    logic        memTimeout;
    logic [15:0] stallCount;

    int nVec = 0;
    int nErr = 0;

    // Behavioural model: 0 = running, 1 = waiting on memory, 2 = halted
    int mMode    = 0;
    int mWaited  = 0;
    int mStalls  = 0;
    bit mTimeout = 1'b0;
    bit mHalted  = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .idExMemRead (idExMemRead),
        .idExRt      (idExRt),
        .ifIdRs      (ifIdRs),
        .ifIdRt      (ifIdRt),
        .memReq      (memReq),
        .memAck      (memAck),
        .haltInstr   (haltInstr),
`ifdef PIPELINE_STEP_MODE_EN
        .stepMode    (stepMode),
        .stepPulse   (stepPulse),
`endif
        .pcEnable    (pcEnable),
        .ifIdEnable  (ifIdEnable),
        .idExEnable  (idExEnable),
        .exMemEnable (exMemEnable),
        .memWbEnable (memWbEnable),
        .idExFlush   (idExFlush),
        .halted      (halted),
        .memTimeout  (memTimeout),
        .stallCount  (stallCount)
    );

    wire [5:0] w_en = {pcEnable, ifIdEnable, idExEnable, exMemEnable, memWbEnable, idExFlush};

    function automatic bit model_hazard();
        return idExMemRead && (idExRt != 0) && (idExRt == ifIdRs || idExRt == ifIdRt);
    endfunction

    // Expected {pc, ifId, idEx, exMem, memWb, flush} for the current inputs
    function automatic logic [5:0] model_en();
        if (reset || mMode == 2)     return 6'b000000;
        if (mMode == 1)              return memAck ? 6'b111110 : 6'b000000;
        if (haltInstr)               return 6'b000000;
        if (memReq && !memAck)       return 6'b000000;
        if (model_hazard())          return 6'b001111;
        return 6'b111110;
    endfunction

    task automatic model_step();
        logic [5:0] en;
        en = model_en();
        if (reset) begin
            mMode = 0; mWaited = 0; mStalls = 0; mTimeout = 0; mHalted = 0;
        end else begin
            if (mMode != 2 && en[5] == 1'b0 && mStalls < 65535) mStalls++;
            if (mMode == 0) begin
                if (haltInstr) begin
                    mMode = 2; mHalted = 1;
                end else if (memReq && !memAck) begin
                    mMode = 1; mWaited = 0;
                end
            end else if (mMode == 1) begin
                if (memAck) mMode = 0;
                else begin
                    mWaited++;
                    if (mWaited == 256) begin
                        mMode = 2; mHalted = 1; mTimeout = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        idExMemRead = 0; idExRt = 0; ifIdRs = 0; ifIdRt = 0;
        memReq = 0; memAck = 0; haltInstr = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        drive_idle();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        drive_idle();
        idExMemRead = 1; idExRt = 7; ifIdRs = 7; memReq = 1;
        #1;
        nVec++;
        if (w_en !== 6'b000000) begin
            nErr++; $display("FAIL reset_enables: got %b want 000000", w_en);
        end
        tick();
        nVec++;
        if ({stallCount, memTimeout, halted} !== 18'd0) begin
            nErr++; $display("FAIL reset_regs: stall=%0d to=%b halted=%b want 0", stallCount, memTimeout, halted);
        end
        reset = 0;
        drive_idle();
        #1;
        nVec++;
        if (w_en !== 6'b111110) begin
            nErr++; $display("FAIL reset_run: got %b want 111110", w_en);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        idExMemRead = 1; idExRt = 5; ifIdRs = 5; ifIdRt = 9;
        #1;
        nVec++;
        if (w_en !== 6'b001111) begin
            nErr++; $display("FAIL load_use_en: got %b want 001111", w_en);
        end
        tick();
        drive_idle();
        #1;
        nVec++;
        if (stallCount !== 16'd1) begin
            nErr++; $display("FAIL load_use_count: got %0d want 1", stallCount);
        end
        // Match on the Rt operand as well
        idExMemRead = 1; idExRt = 12; ifIdRs = 3; ifIdRt = 12;
        #1;
        nVec++;
        if (w_en !== 6'b001111) begin
            nErr++; $display("FAIL load_use_rt: got %b want 001111", w_en);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        idExMemRead = 1; idExRt = 0; ifIdRs = 0; ifIdRt = 0;
        #1;
        nVec++;
        if (w_en !== 6'b111110) begin
            nErr++; $display("FAIL zero_reg_en: got %b want 111110", w_en);
        end
        tick();
        nVec++;
        if (stallCount !== 16'd0) begin
            nErr++; $display("FAIL zero_reg_count: got %0d want 0", stallCount);
        end
        drive_idle();
    endtask

    task automatic test_mem_stall();
        do_reset();
        memReq = 1; memAck = 1;
        #1;
        nVec++;
        if (w_en !== 6'b111110) begin
            nErr++; $display("FAIL mem_same_cycle_ack: got %b want 111110", w_en);
        end
        tick();
        memAck = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nVec++;
            if (w_en !== 6'b000000) begin
                nErr++; $display("FAIL mem_wait_en[%0d]: got %b want 000000", i, w_en);
            end
            tick();
        end
        memAck = 1;
        #1;
        nVec++;
        if (w_en !== 6'b111110) begin
            nErr++; $display("FAIL mem_ack_en: got %b want 111110", w_en);
        end
        tick();
        drive_idle();
        #1;
        nVec++;
        if (w_en !== 6'b111110 || stallCount !== 16'd3) begin
            nErr++; $display("FAIL mem_return: en=%b stall=%0d want 111110 stall=3", w_en, stallCount);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        memReq = 1;
        tick();
        for (int i = 0; i < 255; i++) tick();
        nVec++;
        if (halted !== 1'b0 || memTimeout !== 1'b0) begin
            nErr++; $display("FAIL timeout_early: halted=%b to=%b after 255 waits want 0 0", halted, memTimeout);
        end
        tick();
        nVec++;
        if (halted !== 1'b1 || memTimeout !== 1'b1 || stallCount !== 16'd257) begin
            nErr++; $display("FAIL timeout_set: halted=%b to=%b stall=%0d want 1 1 257", halted, memTimeout, stallCount);
        end
        memAck = 1;
        #1;
        nVec++;
        if (w_en !== 6'b000000) begin
            nErr++; $display("FAIL halt_en: got %b want 000000", w_en);
        end
        do_reset();
        nVec++;
        if (halted !== 1'b0 || memTimeout !== 1'b0) begin
            nErr++; $display("FAIL timeout_clear: halted=%b to=%b want 0 0", halted, memTimeout);
        end
    endtask

    task automatic test_halt_priority();
        do_reset();
        haltInstr = 1; idExMemRead = 1; idExRt = 4; ifIdRs = 4;
        #1;
        nVec++;
        if (w_en !== 6'b000000) begin
            nErr++; $display("FAIL halt_prio_en: got %b want 000000", w_en);
        end
        tick();
        drive_idle();
        #1;
        nVec++;
        if (halted !== 1'b1 || w_en !== 6'b000000) begin
            nErr++; $display("FAIL halt_prio_state: halted=%b en=%b want 1 000000", halted, w_en);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        memReq = 1;
        tick();
        tick();
        reset = 1;
        #1;
        nVec++;
        if (w_en !== 6'b000000) begin
            nErr++; $display("FAIL mid_wait_reset_en: got %b want 000000", w_en);
        end
        tick();
        reset = 0;
        drive_idle();
        #1;
        nVec++;
        if (w_en !== 6'b111110 || {stallCount, memTimeout, halted} !== 18'd0) begin
            nErr++; $display("FAIL mid_wait_reset: en=%b stall=%0d to=%b halted=%b want 111110 0 0 0",
                             w_en, stallCount, memTimeout, halted);
        end
        // A fresh wait must run the full 256 cycles before timing out
        memReq = 1;
        tick();
        for (int i = 0; i < 255; i++) tick();
        nVec++;
        if (halted !== 1'b0) begin
            nErr++; $display("FAIL mid_wait_counter_clear: halted=%b want 0", halted);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [5:0] expEn;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            idExMemRead = $urandom_range(0, 1);
            idExRt      = 5'($urandom_range(0, 3));
            ifIdRs      = 5'($urandom_range(0, 3));
            ifIdRt      = 5'($urandom_range(0, 3));
            memReq      = ($urandom_range(0, 3) == 0);
            memAck      = $urandom_range(0, 1);
            haltInstr   = ($urandom_range(0, 59) == 0);
            #1;
            expEn = model_en();
            nVec++;
            if (w_en !== expEn) begin
                nErr++; $display("FAIL rand_en[%0d]: got %b want %b", i, w_en, expEn);
            end
            tick();
            nVec++;
            if (stallCount !== 16'(mStalls) || memTimeout !== mTimeout || halted !== mHalted) begin
                nErr++; $display("FAIL rand_regs[%0d]: stall=%0d to=%b halted=%b want %0d %b %b",
                                 i, stallCount, memTimeout, halted, mStalls, mTimeout, mHalted);
            end
        end
        reset = 0;
        drive_idle();
    endtask

    initial begin
        reset = 1;
        drive_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_mem_stall();
        test_timeout();
        test_halt_priority();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk, input, 1, single clock, all state updates on its rising edge.
REQ-002 The block SHALL have reset, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have idExMemRead, input, 1, the instruction in ID/EX is a load.
REQ-004 The block SHALL have idExRt, input, 5, load destination register in ID/EX.
REQ-005 The block SHALL have ifIdRs and ifIdRt, inputs, 5 each, source registers of the instruction in IF/ID.
REQ-006 The block SHALL have memReq, input, 1, MEM stage is accessing data memory this cycle.
REQ-007 The block SHALL have memAck, input, 1, data memory access completes this cycle.
REQ-008 The block SHALL have haltInstr, input, 1, a halt instruction sits in MEM/WB.
REQ-009 The block SHALL have pcEnable, ifIdEnable, idExEnable, exMemEnable and memWbEnable, outputs, 1 each, load enables for the PC and for each pipeline latch.
REQ-010 The block SHALL have idExFlush, output, 1, loads a bubble (all control bits zero) into ID/EX.
REQ-011 The block SHALL have halted, output, 1, the pipeline is frozen by a halt.
REQ-012 The block SHALL have memTimeout, output, 1, sticky flag for a memory access that never completed.
REQ-013 The block SHALL have stallCount, output, 16, number of stall cycles seen.

Function
REQ-014 The block SHALL implement exactly three states: RUN, MEM_WAIT and HALT; the enables and idExFlush SHALL be combinational from the state and the inputs, and all other outputs SHALL be registered.
REQ-015 In RUN with no hazard, all five enables SHALL be 1 and idExFlush SHALL be 0.
REQ-016 A load-use hazard SHALL exist when idExMemRead=1, idExRt!=0, and idExRt equals ifIdRs or ifIdRt.
REQ-017 On a load-use hazard in RUN, pcEnable and ifIdEnable SHALL be 0, idExFlush SHALL be 1, the other enables SHALL be 1, and the state SHALL remain RUN, giving one bubble per hazard cycle.
REQ-018 In RUN with memReq=1 and memAck=0, all enables SHALL be 0, idExFlush SHALL be 0, and the next state SHALL be MEM_WAIT.
REQ-019 In RUN with memReq=1 and memAck=1 in the same cycle, there SHALL be no stall.
REQ-020 In MEM_WAIT, all enables SHALL be 0 until memAck=1; in the memAck cycle all enables SHALL be 1 and the next state SHALL be RUN.
REQ-021 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without memAck.
REQ-022 When the wait counter reaches 255 with memAck=0, memTimeout SHALL be set to 1 and the next state SHALL be HALT.
REQ-023 In RUN, haltInstr=1 SHALL force all enables to 0 that cycle and make the next state HALT.
REQ-024 Priority in RUN SHALL be haltInstr, then the memory stall, then the load-use hazard; idExFlush SHALL be 0 whenever a higher-priority event applies.
REQ-025 In HALT, all enables SHALL be 0 and halted SHALL be 1; only reset SHALL leave HALT.
REQ-026 stallCount SHALL increment in every RUN or MEM_WAIT cycle where pcEnable=0, and SHALL saturate at 0xFFFF.

Reset
REQ-027 While reset=1, all enables and idExFlush SHALL be 0.
REQ-028 While reset=1, the state SHALL be RUN on the next edge, and halted, memTimeout, stallCount and the wait counter SHALL be set to 0.
REQ-029 Reset SHALL take priority over every other input in any state, including mid-MEM_WAIT and HALT.

Configuration
REQ-030 With macro PIPELINE_STEP_MODE_EN defined, the block SHALL add inputs stepMode and stepPulse, 1 bit each.
REQ-031 With PIPELINE_STEP_MODE_EN defined and stepMode=1, RUN-state enables SHALL be applied only in cycles where stepPulse=1; in all other RUN cycles the enables SHALL be 0 and those cycles SHALL NOT count in stallCount.
REQ-032 Without PIPELINE_STEP_MODE_EN, stepMode and stepPulse SHALL be absent and the behaviour SHALL be as in REQ-014 to REQ-026.

Verification
REQ-033 The bench SHALL drive idExMemRead=1, idExRt=5, ifIdRs=5 for one cycle and check pcEnable=0, ifIdEnable=0, idExFlush=1, memWbEnable=1, stallCount=1.
REQ-034 The bench SHALL drive idExRt=0 with ifIdRs=0 and idExMemRead=1 and check no stall and idExFlush=0.
REQ-035 The bench SHALL drive memReq=1, hold memAck=0 for 3 cycles, then assert memAck=1, and check enables at 0 for 3 cycles, 1 in the ack cycle, a return to RUN, and stallCount=3.
REQ-036 The bench SHALL drive memReq=1 and never assert memAck, and check memTimeout=1 and halted=1 after 256 wait cycles, then check that reset clears both.
REQ-037 The bench SHALL drive haltInstr=1 and a load-use hazard in the same cycle, and check idExFlush=0, all enables 0, and halted=1 on the next cycle.
REQ-038 The bench SHALL assert reset in the 2nd cycle of MEM_WAIT and check the state returns to RUN with all counters at 0.
